// File: rtl/multiword_cla_sequencer_pkg.sv
// Shared types and helpers for the multi-word carry-lookahead add/subtract engine.
package multiword_cla_sequencer_pkg;

    // Sequencer states: waiting for operands, stepping words, holding the result.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seq_state_e;

    // Word-index width; never narrower than one bit so the index register always exists.
    function automatic int idx_width(input int nwords);
        int w;
        w = $clog2(nwords);
        if (w < 1) begin
            w = 1;
        end else begin
            w = w;
        end
        return w;
    endfunction

endpackage

// File: rtl/multiword_cla_sequencer_cla.sv
// Shared NBIT-bit carry-lookahead adder built from NBITTOCELL-bit lookahead cells.
// Within a cell the bit carries come from generate/propagate prefixes that do not
// depend on the cell carry-in; cells chain through their group generate/propagate.
module NBitCarryLookaheadAdder #(
    parameter int NBIT       = 16,
    parameter int NBITTOCELL = 4
) (
    input  logic [NBIT-1:0] a,
    input  logic [NBIT-1:0] b,
    input  logic            cin,
    output logic [NBIT-1:0] s,
    output logic            cout
);

    localparam int NCELL = NBIT / NBITTOCELL;

    logic [NBIT-1:0]  gen_s;
    logic [NBIT-1:0]  prop_s;
    logic [NBIT-1:0]  carry_s;
    logic [NCELL:0]   cell_carry_s;

    // Generate/propagate, per-bit lookahead carries and cell-to-cell group carries.
    always_comb begin
        logic gpre_v;
        logic ppre_v;
        gen_s        = a & b;
        prop_s       = a ^ b;
        carry_s      = '0;
        cell_carry_s = '0;
        gpre_v       = 1'b0;
        ppre_v       = 1'b1;
        cell_carry_s[0] = cin;
        for (int k = 0; k < NCELL; k++) begin
            gpre_v = 1'b0;
            ppre_v = 1'b1;
            for (int j = 0; j < NBITTOCELL; j++) begin
                carry_s[k*NBITTOCELL + j] = gpre_v | (ppre_v & cell_carry_s[k]);
                gpre_v = gen_s[k*NBITTOCELL + j] | (prop_s[k*NBITTOCELL + j] & gpre_v);
                ppre_v = prop_s[k*NBITTOCELL + j] & ppre_v;
            end
            cell_carry_s[k+1] = gpre_v | (ppre_v & cell_carry_s[k]);
        end
    end

    assign s    = prop_s ^ carry_s;
    assign cout = cell_carry_s[NCELL];

endmodule

// File: rtl/multiword_cla_sequencer.sv
// Multi-precision add/subtract engine: streams NWORDS words, LSW first, through one
// shared carry-lookahead adder and carries between words in a register.
module multiword_cla_sequencer
    import multiword_cla_sequencer_pkg::*;
#(
    parameter int NBIT       = 16,
    parameter int NBITTOCELL = 4,
    parameter int NWORDS     = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [NBIT*NWORDS-1:0] op_a,
    input  logic [NBIT*NWORDS-1:0] op_b,
    input  logic                   op_sub,
    input  logic                   cin,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [NBIT*NWORDS-1:0] result,
    output logic                   cout,
    output logic                   overflow
);

    localparam int W    = NBIT * NWORDS;
    localparam int IDXW = idx_width(NWORDS);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NWORDS - 1);

    seq_state_e      state_r;
    logic [IDXW-1:0] idx_r;
    logic            carry_r;
    logic [W-1:0]    a_r;
    logic [W-1:0]    b_r;
    logic [W-1:0]    result_r;
    logic            cout_r;
    logic            overflow_r;
    logic            out_valid_r;
    logic            in_ready_r;

    logic [NBIT-1:0] word_a_s;
    logic [NBIT-1:0] word_b_s;
    logic [NBIT-1:0] sum_s;
    logic            sum_cout_s;

    // Select the current word of each latched operand for the shared adder.
    always_comb begin
        word_a_s = a_r[int'(idx_r)*NBIT +: NBIT];
        word_b_s = b_r[int'(idx_r)*NBIT +: NBIT];
    end

    NBitCarryLookaheadAdder #(
        .NBIT       (NBIT),
        .NBITTOCELL (NBITTOCELL)
    ) u_cla (
        .a    (word_a_s),
        .b    (word_b_s),
        .cin  (carry_r),
        .s    (sum_s),
        .cout (sum_cout_s)
    );

    // Sequencer FSM: accept operands, step one word per cycle, hold result until taken.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            idx_r       <= '0;
            carry_r     <= 1'b0;
            a_r         <= '0;
            b_r         <= '0;
            result_r    <= '0;
            cout_r      <= 1'b0;
            overflow_r  <= 1'b0;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid && in_ready_r) begin
                        a_r        <= op_a;
                        b_r        <= op_sub ? ~op_b : op_b;
                        carry_r    <= op_sub ? 1'b1 : cin;
                        idx_r      <= '0;
                        in_ready_r <= 1'b0;
                        state_r    <= RUN;
                    end
                end
                RUN: begin
                    result_r[int'(idx_r)*NBIT +: NBIT] <= sum_s;
                    carry_r <= sum_cout_s;
                    if (idx_r == LAST_IDX) begin
                        cout_r      <= sum_cout_s;
                        // Same-sign operands producing an opposite-sign result.
                        overflow_r  <= (a_r[W-1] == b_r[W-1]) && (sum_s[NBIT-1] != a_r[W-1]);
                        out_valid_r <= 1'b1;
                        state_r     <= DONE;
                    end else begin
                        idx_r <= idx_r + IDXW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state_r     <= IDLE;
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                    in_ready_r  <= 1'b1;
                    state_r     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign result    = result_r;
    assign cout      = cout_r;
    assign overflow  = overflow_r;

endmodule

// File: tb/tb_multiword_cla_sequencer.sv
// Directed self-checking bench for multiword_cla_sequencer (NBIT=16, NWORDS=4).
module tb_multiword_cla_sequencer;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] op_a;
    logic [63:0] op_b;
    logic        op_sub;
    logic        cin;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] result;
    logic        cout;
    logic        overflow;

    int n_checks;
    int n_errors;

    multiword_cla_sequencer #(
        .NBIT       (16),
        .NBITTOCELL (4),
        .NWORDS     (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .op_sub    (op_sub),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .cout      (cout),
        .overflow  (overflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // Present a request, wait for the result with a bounded wait, check it, then take it.
    task automatic run_op(input string tag, input logic [63:0] a, input logic [63:0] b,
                          input logic sub, input logic c,
                          input logic [63:0] exp_res, input logic exp_cout, input logic exp_ovf);
        int lat;
        @(negedge clk);
        op_a = a; op_b = b; op_sub = sub; cin = c;
        in_valid = 1'b1; out_ready = 1'b0;
        check_eq({tag, "_in_ready_idle"}, 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check_eq({tag, "_in_ready_busy"}, 64'(in_ready), 64'd0);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check_eq({tag, "_latency"}, 64'(lat), 64'd4);
        check_eq({tag, "_result"}, result, exp_res);
        check_eq({tag, "_cout"}, 64'(cout), 64'(exp_cout));
        check_eq({tag, "_overflow"}, 64'(overflow), 64'(exp_ovf));
        check_eq({tag, "_in_ready_done"}, 64'(in_ready), 64'd0);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check_eq({tag, "_out_valid_taken"}, 64'(out_valid), 64'd0);
        check_eq({tag, "_in_ready_back"}, 64'(in_ready), 64'd1);
    endtask

    initial begin
        int lat;
        n_checks = 0; n_errors = 0;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        op_a = 64'd0; op_b = 64'd0; op_sub = 1'b0; cin = 1'b0;
        #1;
        check_eq("rst_result", result, 64'd0);
        check_eq("rst_out_valid", 64'(out_valid), 64'd0);
        check_eq("rst_cout", 64'(cout), 64'd0);
        check_eq("rst_overflow", 64'(overflow), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_eq("rst_in_ready", 64'(in_ready), 64'd1);

        run_op("add_wrap", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'd0, 1'b1, 1'b0);
        run_op("add_cin", 64'd1, 64'd1, 1'b0, 1'b1, 64'd3, 1'b0, 1'b0);
        run_op("sub_borrow", 64'd0, 64'd1, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
        run_op("add_ovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1);
        run_op("sub_ovf", 64'h8000_0000_0000_0000, 64'd1, 1'b1, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1);

        // Backpressure: hold the result for 3 cycles, then take it with a request waiting.
        @(negedge clk);
        op_a = 64'h1234_5678_9ABC_DEF0; op_b = 64'h1111_1111_1111_1111;
        op_sub = 1'b0; cin = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check_eq("bp_latency", 64'(lat), 64'd4);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check_eq("bp_out_valid", 64'(out_valid), 64'd1);
            check_eq("bp_result", result, 64'h2345_6789_ABCD_F001);
            check_eq("bp_cout", 64'(cout), 64'd0);
            check_eq("bp_overflow", 64'(overflow), 64'd0);
            check_eq("bp_in_ready", 64'(in_ready), 64'd0);
        end
        @(negedge clk);
        op_a = 64'hFFFF_0000_FFFF_0000; op_b = 64'h0001_0000_0001_0000;
        op_sub = 1'b0; cin = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check_eq("b2b_out_taken", 64'(out_valid), 64'd0);
        check_eq("b2b_in_ready_idle", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check_eq("b2b_accepted", 64'(in_ready), 64'd0);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check_eq("b2b_latency", 64'(lat), 64'd4);
        check_eq("b2b_result", result, 64'h0000_0001_0000_0000);
        check_eq("b2b_cout", 64'(cout), 64'd1);
        check_eq("b2b_overflow", 64'(overflow), 64'd0);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;

        // Reset while the word index is 2 in RUN.
        @(negedge clk);
        op_a = 64'hFFFF_FFFF_FFFF_FFFF; op_b = 64'd0;
        op_sub = 1'b0; cin = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("mid_partial_nonzero", 64'(result != 64'd0), 64'd1);
        rst = 1'b1;
        #1;
        check_eq("mid_rst_result", result, 64'd0);
        check_eq("mid_rst_out_valid", 64'(out_valid), 64'd0);
        check_eq("mid_rst_cout", 64'(cout), 64'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_eq("mid_rst_in_ready", 64'(in_ready), 64'd1);
        run_op("after_rst", 64'd2, 64'd3, 1'b0, 1'b0, 64'd5, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
